// File: rtl/ascon_serial_host_if.sv
// Bit-serial port between the Ascon host driver (master) and the Ascon core (slave).
// Masked data lanes, randomness lanes, start levels, serial results and core status.
interface ascon_serial_host_if;
    logic       core_rst;
    logic [2:0] keyxSI;
    logic [2:0] noncexSI;
    logic [2:0] associated_dataxSI;
    logic [2:0] plain_textxSI;
    logic [6:0] r_64xSI;
    logic [2:0] r_128xSI;
    logic [2:0] r_ptxSI;
    logic       encryption_startxSI;
    logic       decryption_startxSI;
    logic       cipher_textxSO;
    logic       tagxSO;
    logic       plain_textxS0;
    logic       dec_tagxSO;
    logic       encryption_readyxSO;
    logic       decryption_readyxSO;
    logic       message_authentication;

    modport master (
        output core_rst, keyxSI, noncexSI, associated_dataxSI, plain_textxSI,
        output r_64xSI, r_128xSI, r_ptxSI, encryption_startxSI, decryption_startxSI,
        input  cipher_textxSO, tagxSO, plain_textxS0, dec_tagxSO,
        input  encryption_readyxSO, decryption_readyxSO, message_authentication
    );

    modport slave (
        input  core_rst, keyxSI, noncexSI, associated_dataxSI, plain_textxSI,
        input  r_64xSI, r_128xSI, r_ptxSI, encryption_startxSI, decryption_startxSI,
        output cipher_textxSO, tagxSO, plain_textxS0, dec_tagxSO,
        output encryption_readyxSO, decryption_readyxSO, message_authentication
    );
endinterface

// File: rtl/ascon_serial_host.sv
// Host driver for the bit-serial Ascon core: shifts key/nonce/AD/text in, collects result + tag.
// Define ASCON_HOST_RNG_EN to use an internal xorshift32 instead of rnd_in for the mask bits.
module ascon_serial_host #(
    parameter int unsigned K       = 128,
    parameter int unsigned L       = 80,
    parameter int unsigned Y       = 80,
    parameter int unsigned TIMEOUT = 4096,
    parameter logic [31:0] SEED    = 32'h1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [K-1:0]        key,
    input  logic [127:0]        nonce,
    input  logic [L-1:0]        ad,
    input  logic [Y-1:0]        din,
    input  logic [20:0]         rnd_in,
    ascon_serial_host_if.master core,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [Y-1:0]        dout,
    output logic [127:0]        tag_out,
    output logic                auth_ok
);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StCrst, StShift, StGo, StCollect, StDone} state_e;

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic           mode_q, err_q, auth_q;
    logic [K-1:0]   key_sr;
    logic [127:0]   nonce_sr;
    logic [L-1:0]   ad_sr;
    logic [Y-1:0]   din_sr, dout_q;
    logic [127:0]   tag_q;
    logic           latch, shift_en, collect_en, set_err;
    logic           ready, res_bit, tag_bit;
    logic [20:0]    rnd;

`ifdef ASCON_HOST_RNG_EN
    logic [31:0] rng_q, rng_t0, rng_t1, rng_t2;
    logic        unused_rnd_in;

    assign unused_rnd_in = ^rnd_in;
    assign rng_t0 = rng_q ^ (rng_q << 13);
    assign rng_t1 = rng_t0 ^ (rng_t0 >> 17);
    assign rng_t2 = rng_t1 ^ (rng_t1 << 5);
    assign rnd    = rng_q[20:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rng_q <= SEED;
        end else if (state_q != StIdle) begin
            rng_q <= rng_t2;
        end
    end
`else
    assign rnd = rnd_in;
`endif

    assign ready   = mode_q ? core.decryption_readyxSO : core.encryption_readyxSO;
    assign res_bit = mode_q ? core.plain_textxS0 : core.cipher_textxSO;
    assign tag_bit = mode_q ? core.dec_tagxSO : core.tagxSO;

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign err     = err_q;
    assign dout    = dout_q;
    assign tag_out = tag_q;
    assign auth_ok = auth_q;

    always_comb begin
        state_d                  = state_q;
        cnt_d                    = cnt_q;
        wait_d                   = wait_q;
        latch                    = 1'b0;
        shift_en                 = 1'b0;
        collect_en               = 1'b0;
        set_err                  = 1'b0;
        core.core_rst            = 1'b0;
        core.keyxSI              = '0;
        core.noncexSI            = '0;
        core.associated_dataxSI  = '0;
        core.plain_textxSI       = '0;
        core.r_64xSI             = '0;
        core.r_128xSI            = '0;
        core.r_ptxSI             = '0;
        core.encryption_startxSI = 1'b0;
        core.decryption_startxSI = 1'b0;
        unique case (state_q)
            StIdle: begin
                core.core_rst = 1'b1;
                if (start) begin
                    latch   = 1'b1;
                    state_d = StCrst;
                end
            end
            StCrst: begin
                core.core_rst = 1'b1;
                cnt_d         = '0;
                state_d       = StShift;
            end
            StShift: begin
                // Field MSBs sit at the top of each shift register; zeros fill in behind.
                core.keyxSI             = {rnd[1], rnd[0], key_sr[K-1]};
                core.noncexSI           = {rnd[3], rnd[2], nonce_sr[127]};
                core.associated_dataxSI = {rnd[5], rnd[4], ad_sr[L-1]};
                core.plain_textxSI      = {rnd[7], rnd[6], din_sr[Y-1]};
                core.r_64xSI            = rnd[14:8];
                core.r_128xSI           = rnd[17:15];
                core.r_ptxSI            = rnd[20:18];
                shift_en                = 1'b1;
                if (cnt_q == 8'd129) begin
                    wait_d  = '0;
                    state_d = StGo;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGo: begin
                core.encryption_startxSI = ~mode_q;
                core.decryption_startxSI = mode_q;
                if (ready) begin
                    cnt_d   = '0;
                    state_d = StCollect;
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    state_d = StDone;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StCollect: begin
                core.encryption_startxSI = ~mode_q;
                core.decryption_startxSI = mode_q;
                collect_en               = 1'b1;
                if (cnt_q == 8'd127) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= 1'b0;
            key_sr   <= '0;
            nonce_sr <= '0;
            ad_sr    <= '0;
            din_sr   <= '0;
            dout_q   <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            auth_q   <= 1'b0;
        end else begin
            if (latch) begin
                mode_q   <= mode;
                key_sr   <= key;
                nonce_sr <= nonce;
                ad_sr    <= ad;
                din_sr   <= din;
                dout_q   <= '0;
                tag_q    <= '0;
                err_q    <= 1'b0;
                auth_q   <= 1'b0;
            end
            if (shift_en) begin
                key_sr   <= key_sr << 1;
                nonce_sr <= nonce_sr << 1;
                ad_sr    <= ad_sr << 1;
                din_sr   <= din_sr << 1;
            end
            if (collect_en) begin
                // LSB-first stream: shifting in from the top lands sample 0 at bit 0.
                tag_q <= {tag_bit, tag_q[127:1]};
                if (32'(cnt_q) < Y) begin
                    dout_q <= {res_bit, dout_q[Y-1:1]};
                end
                if (cnt_q == 8'd0) begin
                    auth_q <= mode_q ? core.message_authentication : 1'b1;
                end
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ascon_serial_host.sv
// Self-checking bench for ascon_serial_host: behavioural core model driven from a cycle schedule,
// random data and mask words, timeout and mid-operation reset scenarios.
module tb_ascon_serial_host;
    localparam int unsigned K = 80;
    localparam int unsigned L = 80;
    localparam int unsigned Y = 80;
    localparam int unsigned TO = 16;
    localparam logic [31:0] SEED = 32'h1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, mode;
    logic [79:0]  key, ad, din;
    logic [127:0] nonce;
    logic [20:0]  rnd_in;
    logic         busy, done, err, auth_ok;
    logic [79:0]  dout;
    logic [127:0] tag_out;
    logic [31:0]  x;
    int           n_checks = 0;
    int           n_fail = 0;

    ascon_serial_host_if cif ();

    ascon_serial_host #(.K(K), .L(L), .Y(Y), .TIMEOUT(TO), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .nonce(nonce), .ad(ad),
        .din(din), .rnd_in(rnd_in), .core(cif), .busy(busy), .done(done), .err(err),
        .dout(dout), .tag_out(tag_out), .auth_ok(auth_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] v);
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    function automatic logic [20:0] lane_word();
        return {cif.r_ptxSI, cif.r_128xSI, cif.r_64xSI, cif.plain_textxSI[2:1],
                cif.associated_dataxSI[2:1], cif.noncexSI[2:1], cif.keyxSI[2:1]};
    endfunction

    function automatic logic [79:0] rand80();
        logic [95:0] v;
        v = {$urandom, $urandom, $urandom};
        return v[79:0];
    endfunction

    function automatic logic [20:0] exp_word();
`ifdef ASCON_HOST_RNG_EN
        return x[20:0];
`else
        return rnd_in;
`endif
    endfunction

    task automatic core_idle();
        cif.encryption_readyxSO    = 1'b0;
        cif.decryption_readyxSO    = 1'b0;
        cif.cipher_textxSO         = 1'b0;
        cif.plain_textxS0          = 1'b0;
        cif.tagxSO                 = 1'b0;
        cif.dec_tagxSO             = 1'b0;
        cif.message_authentication = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rst"}, 256'(cif.core_rst), 256'd1);
        check({tag, "_lanes"}, 256'({cif.keyxSI, cif.noncexSI, cif.associated_dataxSI,
              cif.plain_textxSI, cif.r_64xSI, cif.r_128xSI, cif.r_ptxSI}), 256'd0);
        check({tag, "_ctl"}, 256'({cif.encryption_startxSI, cif.decryption_startxSI, busy, done,
              err, auth_ok}), 256'd0);
        check({tag, "_data"}, 256'({dout, tag_out}), 256'd0);
    endtask

    // lat < 0: core never raises ready. rst_at > 0: assert rst after that edge and stop.
    task automatic run_op(input logic m, input int lat, input logic ab, input logic [79:0] k_in,
                          input logic [79:0] ct, input logic [127:0] tg, input int rst_at);
        logic [129:0] o_key, o_non, o_ad, o_pt;
        logic [79:0]  k_l, d_l, a_l;
        logic [127:0] n_l;
        int done_e, end_e, dn_cnt, dn_edge, bad_rnd, bad_rst, k;
        k_l = k_in; d_l = rand80(); a_l = rand80(); n_l = {$urandom, $urandom, $urandom, $urandom};
        done_e = (lat >= 0) ? 261 + lat : 132 + int'(TO);
        end_e  = (rst_at > 0) ? rst_at : done_e + 1;
        dn_cnt = 0; dn_edge = 0; bad_rnd = 0; bad_rst = 0;
        o_key = '0; o_non = '0; o_ad = '0; o_pt = '0;
        @(negedge clk);
        start = 1'b1; mode = m; key = k_l; din = d_l; ad = a_l; nonce = n_l;
        for (int e = 1; e <= end_e; e++) begin
            @(posedge clk);
            #1;
`ifdef ASCON_HOST_RNG_EN
            if (e >= 2) x = xs(x);
`endif
            start = (e == 10);
            mode = ~m; key = rand80(); din = rand80(); ad = rand80(); nonce = ~nonce;
            rnd_in = 21'($urandom);
            if (lat >= 0 && e == 132 + lat) begin
                cif.encryption_readyxSO = ~m;
                cif.decryption_readyxSO = m;
            end
            k = e - (133 + lat);
            if (lat >= 0 && k >= 0 && k < 128) begin
                cif.tagxSO     = m ? 1'($urandom) : tg[k];
                cif.dec_tagxSO = m ? tg[k] : 1'($urandom);
                cif.cipher_textxSO = (k < 80 && !m) ? ct[k] : 1'($urandom);
                cif.plain_textxS0  = (k < 80 && m) ? ct[k] : 1'($urandom);
                cif.message_authentication = (k == 0) ? ab : ~ab;
            end
            if (e == done_e) core_idle();
            #1;
            if (e == 1) begin
                check("crst_state", 256'({cif.core_rst, busy, err}), 256'(3'b110));
                check("crst_lanes", 256'(lane_word()), 256'd0);
            end else if (e <= 131) begin
                o_key[131-e] = cif.keyxSI[0];
                o_non[131-e] = cif.noncexSI[0];
                o_ad[131-e]  = cif.associated_dataxSI[0];
                o_pt[131-e]  = cif.plain_textxSI[0];
                if (lane_word() !== exp_word()) bad_rnd++;
                if (cif.core_rst !== 1'b0) bad_rst++;
            end
            if (e == 132) begin
                check("go_level", 256'({cif.encryption_startxSI, cif.decryption_startxSI}),
                      256'({~m, m}));
                check("go_lanes", 256'(lane_word()), 256'd0);
                check("sh_key", 256'(o_key), 256'({k_l, 50'd0}));
                check("sh_nonce", 256'(o_non), 256'({n_l, 2'd0}));
                check("sh_ad", 256'(o_ad), 256'({a_l, 50'd0}));
                check("sh_text", 256'(o_pt), 256'({d_l, 50'd0}));
                check("sh_rnd", 256'(bad_rnd), 256'd0);
                check("sh_rst", 256'(bad_rst), 256'd0);
            end
            if (lat >= 0 && e == 197 + lat)
                check("col_level", 256'({cif.encryption_startxSI, cif.decryption_startxSI}),
                      256'({~m, m}));
            if (done === 1'b1) begin
                dn_cnt++;
                dn_edge = e;
            end
            if (rst_at > 0 && e == rst_at) begin
                check("mid_key_bit", 256'(cif.keyxSI[0]), 256'(k_l[79-(e-2)]));
                rst = 1'b1;
                x = SEED;
                core_idle();
                #1;
                check_reset_outputs("midrst");
                @(negedge clk);
                rst = 1'b0;
            end
        end
        if (rst_at == 0) begin
            check("done_count", 256'(dn_cnt), 256'd1);
            check("done_edge", 256'(dn_edge), 256'(done_e));
            check("idle_state", 256'({cif.core_rst, busy, done}), 256'(3'b100));
            check("err", 256'(err), 256'(lat < 0));
            if (lat >= 0) begin
                check("tag_out", 256'(tag_out), 256'(tg));
                check("dout", 256'(dout), 256'(ct));
                check("auth_ok", 256'(auth_ok), 256'(m ? ab : 1'b1));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; key = '0; nonce = '0; ad = '0; din = '0;
        rnd_in = '0; x = SEED;
        core_idle();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 3, 1'b0, 80'h0123_4567_89AB_CDEF_0123, 80'h0F1E_2D3C_4B5A_6978_8796,
               128'hA55A_A55A_A55A_A55A_A55A_A55A_A55A_A55A, 0);
        run_op(1'b1, 0, 1'b0, rand80(), rand80(), {$urandom, $urandom, $urandom, $urandom}, 0);
        run_op(1'b1, 7, 1'b1, rand80(), rand80(), {$urandom, $urandom, $urandom, $urandom}, 0);
        run_op(1'($urandom), -1, 1'b0, rand80(), rand80(), 128'd0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", 256'({err, cif.core_rst, busy}), 256'(3'b110));
        run_op(1'b0, 2, 1'b0, rand80(), rand80(), {$urandom, $urandom, $urandom, $urandom}, 52);
        for (int i = 0; i < 3; i++)
            run_op(1'($urandom), int'($urandom_range(0, 12)), 1'($urandom), rand80(), rand80(),
                   {$urandom, $urandom, $urandom, $urandom}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
